// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects A, B and the ALU opcode from switches,
// one debounced "enter" press at a time, then captures the ALU result and
// flags for the display stage. A debounced "clear" press aborts from any state.
module alu_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       ALU_Code,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [3:0]       flags,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       flags_q,
    output logic             result_valid,
    output logic [2:0]       state_o
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Button lanes: bit 0 = enter, bit 1 = clear.
    logic [1:0]    s1, s2, deb, deb_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;
    logic          enter_press, clear_press;

    state_t state_q, state_d;
    logic   load_a, load_b, load_code, capture, drop_valid;

    // Synchronize and debounce both buttons; a level change must hold in s2
    // for DEBOUNCE_CYCLES consecutive cycles before deb follows it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments here make s1->s2->deb a real
            // shift chain; blocking ones would collapse it into one flop.
            s1    <= {btn_clear, btn_enter};
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != deb[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        deb[i] <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press       = deb & ~deb_d;
    assign clear_press = press[1];
    assign enter_press = press[0] & ~press[1];  // clear wins over enter

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_A;
        else        state_q <= state_d;
    end

    // Next-state and datapath-control decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_code  = 1'b0;
        capture    = 1'b0;
        drop_valid = 1'b0;
        if (clear_press) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A: if (enter_press) begin
                    load_a  = 1'b1;
                    state_d = S_B;
                end
                S_B: if (enter_press) begin
                    load_b  = 1'b1;
                    state_d = S_OP;
                end
                S_OP: if (enter_press) begin
                    load_code = 1'b1;
                    state_d   = S_EXEC;
                end
                S_EXEC: begin
                    // ALU had this full cycle to settle on the new operands.
                    capture = 1'b1;
                    state_d = S_SHOW;
                end
                S_SHOW: if (enter_press) begin
                    drop_valid = 1'b1;
                    state_d    = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    // Operand, opcode and result holding registers.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_press) begin
            A            <= '0;
            B            <= '0;
            ALU_Code     <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            result_valid <= 1'b0;
        end else begin
            if (load_a)    A        <= sw_data;
            if (load_b)    B        <= sw_data;
            if (load_code) ALU_Code <= sw_data[2:0];
            if (capture) begin
                result_q     <= ALU_Result;
                flags_q      <= flags;
                result_valid <= 1'b1;
            end else if (drop_valid) begin
                result_valid <= 1'b0;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed, table-driven bench for alu_operand_sequencer with DEBOUNCE_CYCLES=4.
module tb_alu_operand_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_data;
    logic       btn_enter, btn_clear;
    logic [3:0] a, b, alu_result, flags, result_q, flags_q;
    logic [2:0] alu_code, state_o;
    logic       result_valid;

    int n_vec  = 0;
    int n_fail = 0;

    alu_operand_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .sw_data(sw_data),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .A(a), .B(b), .ALU_Code(alu_code),
        .ALU_Result(alu_result), .flags(flags),
        .result_q(result_q), .flags_q(flags_q),
        .result_valid(result_valid), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: 000 add, 001 subtract, 010 and, others xor; flags {N,Z,C,V}.
    logic [4:0] t;
    logic       c, v;
    always_comb begin
        t = '0;
        c = 1'b0;
        v = 1'b0;
        alu_result = a ^ b;
        case (alu_code)
            3'b000: begin
                t = {1'b0, a} + {1'b0, b};
                alu_result = t[3:0];
                c = t[4];
                v = (a[3] == b[3]) && (t[3] != a[3]);
            end
            3'b001: begin
                t = {1'b0, a} + {1'b0, ~b} + 5'd1;
                alu_result = t[3:0];
                c = t[4];
                v = (a[3] != b[3]) && (t[3] != a[3]);
            end
            3'b010: alu_result = a & b;
            default: ;
        endcase
        flags = {alu_result[3], alu_result == 4'd0, c, v};
    end

    typedef struct {
        logic [3:0] a_sw, b_sw, code_sw;
        logic [2:0] exp_code;
        logic [3:0] exp_res, exp_flags;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a switch value and a press of `hold` cycles, then let the
    // release debounce out so the next press is clean.
    task automatic press(input logic [3:0] sw, input logic ent, input logic clr, input int hold);
        @(negedge clk);
        sw_data   = sw;
        btn_enter = ent;
        btn_clear = clr;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (2 * N + 4) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{4'b0101, 4'b1001, 4'b0000, 3'b000, 4'b1110, 4'b1000};
        vecs[1] = '{4'b1101, 4'b1101, 4'b0001, 3'b001, 4'b0000, 4'b0110};
        vecs[2] = '{4'b0111, 4'b0001, 4'b0000, 3'b000, 4'b1000, 4'b1001};
        vecs[3] = '{4'b1111, 4'b0001, 4'b0000, 3'b000, 4'b0000, 4'b0110};
        vecs[4] = '{4'b1100, 4'b1010, 4'b1010, 3'b010, 4'b1000, 4'b1000};
        vecs[5] = '{4'b0011, 4'b0101, 4'b1111, 3'b111, 4'b0110, 4'b0000};

        rst_n = 1'b0; sw_data = '0; btn_enter = 1'b0; btn_clear = 1'b0;

        // Reset with buttons toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            btn_enter = ~btn_enter;
            btn_clear = (i == 1);
            check("reset_state", {5'd0, state_o}, 8'd0);
            check("reset_outs", {a, b}, 8'd0);
            check("reset_res", {result_q, flags_q}, 8'd0);
            check("reset_misc", {4'd0, alu_code, result_valid}, 8'd0);
        end
        btn_enter = 1'b0; btn_clear = 1'b0; rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_state", {5'd0, state_o}, 8'd0);
        check("post_reset_a", {4'd0, a}, 8'd0);

        // Glitch: 3-cycle press is rejected.
        press(4'b0101, 1'b1, 1'b0, 3);
        check("glitch_state", {5'd0, state_o}, 8'd0);
        check("glitch_a", {4'd0, a}, 8'd0);

        // Press latency: 10-cycle press acted on at edge 6.
        @(negedge clk);
        sw_data = 4'b0101; btn_enter = 1'b1;
        repeat (6) @(negedge clk);
        check("lat_edge5_state", {5'd0, state_o}, 8'd0);
        @(negedge clk);
        check("lat_edge6_state", {5'd0, state_o}, 8'd1);
        check("lat_edge6_a", {4'd0, a}, 8'h05);
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        check("single_press_state", {5'd0, state_o}, 8'd1);

        // Clear from S_B.
        press(4'b0000, 1'b0, 1'b1, 8);
        check("clear_sb_state", {5'd0, state_o}, 8'd0);
        check("clear_sb_a", {4'd0, a}, 8'd0);

        // Table of full operations, each ending with a re-run press from S_SHOW.
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].a_sw, 1'b1, 1'b0, 8);
            check("vec_a_state", {5'd0, state_o}, 8'd1);
            check("vec_a", {4'd0, a}, {4'd0, vecs[i].a_sw});
            press(vecs[i].b_sw, 1'b1, 1'b0, 8);
            check("vec_b_state", {5'd0, state_o}, 8'd2);
            check("vec_b", {4'd0, b}, {4'd0, vecs[i].b_sw});
            @(negedge clk);
            sw_data = vecs[i].code_sw; btn_enter = 1'b1;
            repeat (7) @(negedge clk);
            check("vec_exec_state", {5'd0, state_o}, 8'd3);
            check("vec_exec_valid", {7'd0, result_valid}, 8'd0);
            check("vec_code", {5'd0, alu_code}, {5'd0, vecs[i].exp_code});
            @(negedge clk);
            check("vec_show_state", {5'd0, state_o}, 8'd4);
            check("vec_valid", {7'd0, result_valid}, 8'd1);
            check("vec_result", {4'd0, result_q}, {4'd0, vecs[i].exp_res});
            check("vec_flags", {4'd0, flags_q}, {4'd0, vecs[i].exp_flags});
            btn_enter = 1'b0;
            repeat (12) @(negedge clk);
            press(4'b0000, 1'b1, 1'b0, 8);
            check("rerun_state", {5'd0, state_o}, 8'd0);
            check("rerun_valid", {7'd0, result_valid}, 8'd0);
            check("rerun_hold", {result_q, flags_q}, {vecs[i].exp_res, vecs[i].exp_flags});
        end

        // Clear and enter together in S_OP: clear wins.
        press(4'b0101, 1'b1, 1'b0, 8);
        press(4'b1001, 1'b1, 1'b0, 8);
        check("prio_pre_state", {5'd0, state_o}, 8'd2);
        press(4'b0011, 1'b1, 1'b1, 8);
        check("prio_state", {5'd0, state_o}, 8'd0);
        check("prio_ab", {a, b}, 8'd0);
        check("prio_code_valid", {4'd0, alu_code, result_valid}, 8'd0);

        // Clear from S_SHOW zeroes captured values.
        press(4'b0111, 1'b1, 1'b0, 8);
        press(4'b0001, 1'b1, 1'b0, 8);
        press(4'b0000, 1'b1, 1'b0, 8);
        check("show_pre_result", {result_q, flags_q}, 8'h89);
        press(4'b0000, 1'b0, 1'b1, 8);
        check("clear_show_res", {result_q, flags_q}, 8'd0);
        check("clear_show_misc", {4'd0, state_o, result_valid}, 8'd0);

        // Reset mid-operation, with enter held across reset release.
        press(4'b0101, 1'b1, 1'b0, 8);
        check("mid_pre_state", {5'd0, state_o}, 8'd1);
        @(negedge clk);
        rst_n = 1'b0; btn_enter = 1'b1; sw_data = 4'b1001;
        @(negedge clk);
        check("mid_reset_state", {5'd0, state_o}, 8'd0);
        check("mid_reset_a", {4'd0, a}, 8'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("held_edge5_state", {5'd0, state_o}, 8'd0);
        @(negedge clk);
        check("held_edge6_state", {5'd0, state_o}, 8'd1);
        check("held_a", {4'd0, a}, 8'h09);
        repeat (8) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        check("held_single_press", {5'd0, state_o}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end stage for the 4-bit ALU, sitting directly upstream of it. It collects operand A, operand B and the 3-bit operation code from board switches, one debounced "enter" press at a time, and drives them to the ALU. It then captures the ALU result and N,Z,C,V flags into holding registers for the display stage. A debounced "clear" press aborts the sequence from any state.

## Interface
- `WIDTH`, default 4: operand and result width.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced button level changes. Must be ≥2. Board builds override it, e.g. 500000.

- `clk`  in  1: single clock; every register updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `sw_data`  in  WIDTH: switch value. Sampled directly, no synchronizer; switches are static when a press completes.
- `btn_enter`  in  1: raw, asynchronous, active-high push button.
- `btn_clear`  in  1: raw, asynchronous, active-high push button.
- `A`  out  WIDTH: operand A to the ALU.
- `B`  out  WIDTH: operand B to the ALU.
- `ALU_Code`  out  3: operation select to the ALU.
- `ALU_Result`  in  WIDTH: combinational result from the ALU.
- `flags`  in  4: ALU flags, ordered {N,Z,C,V}.
- `result_q`  out  WIDTH: captured result.
- `flags_q`  out  4: captured flags.
- `result_valid`  out  1: high while the captured values belong to the current A/B/code.
- `state_o`  out  3: FSM state, driven to LEDs.

## Operation
- **Synchronizer and debouncer (per button).**
  - Two-flop synchronizer `s1`→`s2`.
  - Counter `cnt` increments while `s2`≠`deb`, and resets to 0 while `s2`==`deb`.
  - When `cnt`==`DEBOUNCE_CYCLES`-1 and `s2`≠`deb`: `deb`<=`s2` and `cnt`<=0.
  - Press pulse = `deb` & ~`deb_d`, where `deb_d` is `deb` delayed one cycle.
- **FSM states and `state_o` encoding:** S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
- **Transitions:**
  - S_A + enter: `A`<=`sw_data`, go to S_B.
  - S_B + enter: `B`<=`sw_data`, go to S_OP.
  - S_OP + enter: `ALU_Code`<=`sw_data`[2:0] (upper bits ignored), go to S_EXEC.
  - S_EXEC, unconditional, one cycle: `result_q`<=`ALU_Result`, `flags_q`<=`flags`, `result_valid`<=1, go to S_SHOW.
  - S_SHOW + enter: `result_valid`<=0, go to S_A. `A`, `B`, `ALU_Code`, `result_q` and `flags_q` hold until overwritten.
- **Clear press, any state:** go to S_A and zero `A`, `B`, `ALU_Code`, `result_q`, `flags_q` and `result_valid`.
- **Clear and enter in the same cycle:** clear wins and enter is dropped.
- **Enter during S_EXEC:** ignored. It cannot occur, because presses are ≥2·`DEBOUNCE_CYCLES` apart.
- **Code 3'b111:** accepted and forwarded. Whatever the ALU returns is captured.
- **Unused state encodings 5–7:** return to S_A on the next edge.

## Timing
- **Reset** (`rst_n` low at an edge) forces:
  - all outputs to 0, `state_o`=0;
  - `s1`, `s2`, `deb`, `deb_d` and `cnt` to 0.
  - Reset overrides any in-flight press or state.
- **Button held through reset release:** yields exactly one press, `DEBOUNCE_CYCLES`+2 edges after release.
- **Press latency.** Let edge 0 be the first edge sampling `btn_enter`=1 into `s1`, with N=`DEBOUNCE_CYCLES`.
  - `deb` rises after edge 1+N.
  - The press is high only between edges 1+N and 2+N.
  - The FSM acts on edge 2+N.
- **Glitch rejection:**
  - A level change that holds in `s2` for fewer than N consecutive cycles produces no press.
  - Release is debounced the same way, so a new press requires a debounced low first.
- **ALU path:** the ALU is combinational and is given one full cycle (S_EXEC) from the `ALU_Code` update to the result capture.
- **`result_valid`:** rises the edge after entering S_EXEC, i.e. 1 cycle after the third press is acted on.

## Test plan
- **Reset:** `rst_n`=0 for 3 cycles with buttons toggling → all outputs 0 and `state_o`=0 during and after reset.
- **Basic operation** (N=4, each press ≥8 cycles long): `sw_data` 0101, 1001, 0000.
  - `A`=0101, `B`=1001, `ALU_Code`=000.
  - One cycle later `result_q`=1110, `flags_q`=1000, `result_valid`=1, `state_o`=4.
- **Debounce timing:**
  - `btn_enter` high for 3 cycles → `state_o` stays 0.
  - `btn_enter` high for 10 cycles → press high exactly one cycle, between edges 5 and 6, and `state_o`=1 after edge 6.
- **Clear priority:** in S_OP, `btn_clear` and `btn_enter` asserted together → `state_o`=0 and `A`=`B`=`ALU_Code`=`result_valid`=0.
- **Re-run from S_SHOW:**
  - Enter → `result_valid`=0 with `result_q` held.
  - Then 1101, 1101, 0001 → `result_q`=0000 and `flags_q`[2] (Z)=1.
- **Reset mid-operation:** in S_B with `A`=0101, pulse `rst_n` low one cycle → `state_o`=0 and `A`=0000. A button held across reset release → exactly one press, `state_o`=1.
